// File: rtl/cdc_bits_filt.sv
// Per-bit asynchronous input conditioner: multi-flop synchronizer, persistence filter,
// and registered one-cycle rise/fall pulses on the filtered level.
module cdc_bits_filt #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 4,
  parameter int unsigned      FILT_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             dst_clk,
  input  logic             dst_rst_n,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] dst_sync,
  output logic [WIDTH-1:0] dst,
  output logic [WIDTH-1:0] dst_rise,
  output logic [WIDTH-1:0] dst_fall
);

  localparam int unsigned     CntW   = $clog2(FILT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("cdc_bits_filt: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_bits_filt: STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("cdc_bits_filt: FILT_CYCLES must be >= 1");
  end

  // Stage 0 is the metastable capture flop; pure shift, nothing between stages.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], src};
    end
  end

  assign dst_sync = sync_q[STAGES-1];

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           dst_q, dst_d;
  logic [WIDTH-1:0]           rise_q, rise_d;
  logic [WIDTH-1:0]           fall_q, fall_d;

  always_comb begin
    cnt_d  = '0;
    dst_d  = dst_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (dst_sync[i] != dst_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          // Mismatch has persisted long enough: accept and restart the count.
          dst_d[i]  = dst_sync[i];
          rise_d[i] = dst_sync[i];
          fall_d[i] = ~dst_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      cnt_q  <= '0;
      dst_q  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dst_q  <= dst_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dst      = dst_q;
  assign dst_rise = rise_q;
  assign dst_fall = fall_q;

endmodule
